mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory (1KB instr + 1KB data image) between two requesters.
//  Requesters are instruction fetch (IF) and the load/store unit (LSU); one transaction is outstanding at a time.
//  Sits between the fetch/execute-memory stages and the memory model; in-order, fixed-priority, starvation-guarded.
// PARAMETERS
//  STARVE_LIMIT  4     consecutive IF-losing cycles after which IF wins next arbitration (guard feature only)
//  AW            XLEN  address width (XLEN from riscv_pkg, 32)
// PORTS
//  clk_i         in   1     clock, rising edge
//  rstn_i        in   1     synchronous reset, active-low
//  if_req_i      in   1     IF read request valid
//  if_addr_i     in   AW    IF byte address
//  if_gnt_o      out  1     IF request accepted this cycle
//  if_rvalid_o   out  1     IF read data valid
//  if_rdata_o    out  XLEN  IF read data
//  lsu_req_i     in   1     LSU request valid
//  lsu_we_i      in   1     1 = store, 0 = load
//  lsu_be_i      in   4     byte enables
//  lsu_addr_i    in   AW    LSU byte address
//  lsu_wdata_i   in   XLEN  store data
//  lsu_gnt_o     out  1     LSU request accepted this cycle
//  lsu_rvalid_o  out  1     LSU response valid (load data or store ack)
//  lsu_rdata_o   out  XLEN  LSU load data
//  mem_req_o     out  1     memory request valid (registered)
//  mem_we_o / mem_be_o(4) / mem_addr_o(AW) / mem_wdata_o(XLEN)  out  registered request fields
//  mem_gnt_i     in   1     memory accepted mem_req_o this cycle
//  mem_rvalid_i  in   1     memory response valid (every request, reads and writes)
//  mem_rdata_i   in   XLEN  memory read data
// BEHAVIOUR
//  - FSM arb_state_e: IDLE -> ISSUE -> WAIT_RSP -> IDLE.
//  - IDLE: if any req, select winner, pulse its *_gnt_o (combinational, same cycle), latch fields + owner; -> ISSUE.
//  - Priority: LSU over IF; with guard, IF wins when starve_cnt == STARVE_LIMIT.
//  - ISSUE: mem_req_o=1 with latched fields, held stable until mem_gnt_i; on mem_gnt_i -> WAIT_RSP.
//  - WAIT_RSP: mem_req_o=0; on mem_rvalid_i route to owner: <owner>_rvalid_o=1, rdata=mem_rdata_i, same cycle; -> IDLE.
//  - Non-owner rvalid_o is 0; rdata outputs = mem_rdata_i (qualified by rvalid only).
//  - mem_rvalid_i in IDLE/ISSUE ignored (stale/spurious); mem_gnt_i outside ISSUE ignored.
//  - Min latency req->rvalid: 2 cycles (gnt_o cycle, ISSUE with immediate mem_gnt_i, rvalid next cycle).
//  - New accept only in IDLE: back-to-back spacing >= 3 cycles; no gnt_o while ISSUE/WAIT_RSP.
//  - IF reads: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
//  - Reset (rstn_i=0 at a clock edge, any state): state=IDLE, owner=IF, starve_cnt=0, mem_req_o=0,
//    mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0; in-flight transaction dropped, no rvalid produced.
//  - All *_gnt_o and *_rvalid_o are 0 while rstn_i=0.
// CONFIGURATION
//  - ARB_STARVE_GUARD_EN defined: starve_cnt increments (saturating at STARVE_LIMIT) each IDLE cycle IF requests and LSU wins.
//    It clears when IF wins or IF drops its req; at STARVE_LIMIT, IF beats a simultaneous LSU req.
//  - Undefined: strict LSU priority, no counter; IF may starve indefinitely under continuous LSU traffic.
// STRUCTURE
//  - riscv_pkg additions: arb_state_e {IDLE, ISSUE, WAIT_RSP}; arb_owner_e {OWN_IF, OWN_LSU};
//    mem_req_t struct {we, be[3:0], addr[XLEN-1:0], wdata[XLEN-1:0]}.
//  - Flat module; the priority/starvation select is a natural sub-module: arb_prio_sel.
// TESTING
//  - Single IF read addr 0x10, mem_gnt_i immediate, rvalid+1 rdata 0xDEADBEEF -> if_rvalid_o=1, if_rdata_o=0xDEADBEEF.
//  - IF and LSU req same IDLE cycle (LSU store 0x20, be=4'h3) -> lsu_gnt_o first, mem_we_o=1/mem_be_o=3; IF served after ack.
//  - mem_gnt_i held low 5 cycles in ISSUE -> mem_req_o and fields stable 5 cycles; no new gnt_o to either requester.
//  - GUARD_EN, STARVE_LIMIT=4, both req continuously -> IF granted on 5th arbitration; without macro IF never granted.
//  - rstn_i low in WAIT_RSP, then mem_rvalid_i pulse -> no *_rvalid_o, mem_req_o=0, next IDLE grant normal.
//  - Spurious mem_rvalid_i in IDLE -> both rvalid outputs stay 0, state unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the IF/LSU memory port arbiter
package mem_port_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signals of the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int AW = mem_port_arbiter_pkg::XLEN
) ();
  import mem_port_arbiter_pkg::*;

  logic            if_req_i;
  logic [AW-1:0]   if_addr_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [XLEN-1:0] if_rdata_o;

  logic            lsu_req_i;
  logic            lsu_we_i;
  logic [3:0]      lsu_be_i;
  logic [AW-1:0]   lsu_addr_i;
  logic [XLEN-1:0] lsu_wdata_i;
  logic            lsu_gnt_o;
  logic            lsu_rvalid_o;
  logic [XLEN-1:0] lsu_rdata_o;

  logic            mem_req_o;
  logic            mem_we_o;
  logic [3:0]      mem_be_o;
  logic [AW-1:0]   mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  // Requesters plus memory model side
  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

endinterface

// File: rtl/mem_port_arbiter_prio_sel.sv
// rtl/mem_port_arbiter_prio_sel.sv - fixed LSU-first priority select with starvation override
module mem_port_arbiter_prio_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 3
) (
  input  logic          if_req,
  input  logic          lsu_req,
  input  logic [CW-1:0] starve_cnt,
  output logic          sel_if,
  output logic          sel_lsu
);

  logic if_starved;

  // IF overrides LSU only once it has lost STARVE_LIMIT arbitrations in a row
  always_comb begin
    if_starved = (starve_cnt == CW'(STARVE_LIMIT));
    sel_lsu    = lsu_req && !(if_req && if_starved);
    sel_if     = if_req && !sel_lsu;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/LSU single-port memory arbiter; ARB_STARVE_GUARD_EN enables IF starvation guard
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = XLEN
) (
  input logic               clk_i,
  input logic               rstn_i,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_ISSUE    = ISSUE;
  localparam logic [1:0] ST_WAIT_RSP = WAIT_RSP;
  localparam int         CW          = $clog2(STARVE_LIMIT + 1);

  logic [1:0]    state_q;
  arb_owner_e    owner_q;
  mem_req_t      req_q;
  logic          mem_req_q;
  logic [CW-1:0] starve_cnt;

  logic sel_if;
  logic sel_lsu;
  logic in_idle;
  logic accept_if;
  logic accept_lsu;
  logic rsp_fire;

  mem_port_arbiter_prio_sel #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CW           (CW)
  ) u_prio_sel (
    .if_req     (bus.if_req_i),
    .lsu_req    (bus.lsu_req_i),
    .starve_cnt (starve_cnt),
    .sel_if     (sel_if),
    .sel_lsu    (sel_lsu)
  );

  // Grants and response routing; everything is silenced while reset is held
  always_comb begin
    in_idle    = (state_q == ST_IDLE);
    accept_if  = rstn_i && in_idle && sel_if;
    accept_lsu = rstn_i && in_idle && sel_lsu;
    rsp_fire   = rstn_i && (state_q == ST_WAIT_RSP) && bus.mem_rvalid_i;
  end

  assign bus.if_gnt_o     = accept_if;
  assign bus.lsu_gnt_o    = accept_lsu;
  assign bus.if_rvalid_o  = rsp_fire && (owner_q == OWN_IF);
  assign bus.lsu_rvalid_o = rsp_fire && (owner_q == OWN_LSU);
  assign bus.if_rdata_o   = bus.mem_rdata_i;
  assign bus.lsu_rdata_o  = bus.mem_rdata_i;

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = req_q.we;
  assign bus.mem_be_o    = req_q.be;
  assign bus.mem_addr_o  = AW'(req_q.addr);
  assign bus.mem_wdata_o = req_q.wdata;

`ifdef ARB_STARVE_GUARD_EN
  // Count arbitrations IF loses while still requesting; any IF win or IF drop clears it
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      starve_cnt <= '0;
    end else if (!bus.if_req_i || accept_if) begin
      starve_cnt <= '0;
    end else if (accept_lsu && (starve_cnt != CW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end
`else
  assign starve_cnt = '0;
`endif

  // One transaction at a time: accept in IDLE, hold request until taken, wait for the response
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IF;
      mem_req_q <= 1'b0;
      req_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_lsu) begin
            owner_q   <= OWN_LSU;
            req_q     <= '{we: bus.lsu_we_i, be: bus.lsu_be_i,
                           addr: XLEN'(bus.lsu_addr_i), wdata: bus.lsu_wdata_i};
            mem_req_q <= 1'b1;
            state_q   <= ST_ISSUE;
          end else if (accept_if) begin
            owner_q   <= OWN_IF;
            req_q     <= '{we: 1'b0, be: 4'hF, addr: XLEN'(bus.if_addr_i), wdata: '0};
            mem_req_q <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (bus.mem_rvalid_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  typedef struct {
    bit          lsu;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input bit lsu, input logic [31:0] d);
    exp_t e;
    e.lsu  = lsu;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic check_rsp();
    exp_t e;
    chk("rsp_seen", 32'(bus.if_rvalid_o | bus.lsu_rvalid_o), 32'd1);
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_if_rvalid", 32'(bus.if_rvalid_o), 32'(!e.lsu));
      chk("rsp_lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'(e.lsu));
      chk("rsp_rdata", e.lsu ? bus.lsu_rdata_o : bus.if_rdata_o, e.data);
    end
  endtask

  // Entered just after the edge into ISSUE; leaves just after the edge back into IDLE
  task automatic mem_serve(input int stall, input logic [31:0] rd);
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  be;
    logic        we;
    a  = bus.mem_addr_o;
    w  = bus.mem_wdata_o;
    be = bus.mem_be_o;
    we = bus.mem_we_o;
    for (int i = 0; i < stall; i++) begin
      bus.mem_gnt_i = 1'b0;
      #1;
      chk("stall_req", 32'(bus.mem_req_o), 32'd1);
      chk("stall_addr", bus.mem_addr_o, a);
      chk("stall_wdata", bus.mem_wdata_o, w);
      chk("stall_be_we", {27'd0, bus.mem_we_o, bus.mem_be_o}, {27'd0, we, be});
      chk("stall_no_gnt", {30'd0, bus.if_gnt_o, bus.lsu_gnt_o}, 32'd0);
      tick();
    end
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("issue_req", 32'(bus.mem_req_o), 32'd1);
    chk("issue_no_gnt", {30'd0, bus.if_gnt_o, bus.lsu_gnt_o}, 32'd0);
    tick();
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = rd;
    #1;
    chk("wait_req_low", 32'(bus.mem_req_o), 32'd0);
    check_rsp();
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  initial begin
    bit guard;
    bit exp_if;
`ifdef ARB_STARVE_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    bus.if_req_i     = 1'b1;
    bus.if_addr_i    = 32'h4;
    bus.lsu_req_i    = 1'b1;
    bus.lsu_we_i     = 1'b0;
    bus.lsu_be_i     = 4'hF;
    bus.lsu_addr_i   = '0;
    bus.lsu_wdata_i  = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;

    // Reset: requests asserted, nothing granted, registered fields cleared
    tick();
    tick();
    chk("rst_gnt", {30'd0, bus.if_gnt_o, bus.lsu_gnt_o}, 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("rst_mem_fields", {27'd0, bus.mem_we_o, bus.mem_be_o}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);

    // Single IF read at 0x10
    bus.lsu_req_i = 1'b0;
    bus.if_addr_i = 32'h10;
    rstn_i        = 1'b1;
    #1;
    chk("t1_if_gnt", 32'(bus.if_gnt_o), 32'd1);
    chk("t1_lsu_gnt", 32'(bus.lsu_gnt_o), 32'd0);
    push(1'b0, 32'hDEADBEEF);
    tick();
    bus.if_req_i = 1'b0;
    #1;
    chk("t1_mem_addr", bus.mem_addr_o, 32'h10);
    chk("t1_mem_fields", {27'd0, bus.mem_we_o, bus.mem_be_o}, 32'h0F);
    chk("t1_mem_wdata", bus.mem_wdata_o, 32'd0);
    mem_serve(0, 32'hDEADBEEF);

    // Spurious rvalid in IDLE is ignored, arbiter still accepts normally
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h5555AAAA;
    #1;
    chk("t6_idle_rvalid", {30'd0, bus.if_rvalid_o, bus.lsu_rvalid_o}, 32'd0);
    chk("t6_idle_req", 32'(bus.mem_req_o), 32'd0);
    tick();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h18;
    #1;
    chk("t6_if_gnt", 32'(bus.if_gnt_o), 32'd1);
    push(1'b0, 32'h01020304);
    tick();
    bus.if_req_i = 1'b0;
    #1;
    chk("t6_issue_rvalid", {30'd0, bus.if_rvalid_o, bus.lsu_rvalid_o}, 32'd0);
    chk("t6_issue_req", 32'(bus.mem_req_o), 32'd1);
    bus.mem_rvalid_i = 1'b0;
    mem_serve(0, 32'h01020304);

    // IF and LSU together: LSU store first, IF after the store ack
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 32'h44;
    bus.lsu_req_i   = 1'b1;
    bus.lsu_we_i    = 1'b1;
    bus.lsu_be_i    = 4'h3;
    bus.lsu_addr_i  = 32'h20;
    bus.lsu_wdata_i = 32'h12345678;
    #1;
    chk("t2_lsu_gnt", 32'(bus.lsu_gnt_o), 32'd1);
    chk("t2_if_gnt", 32'(bus.if_gnt_o), 32'd0);
    push(1'b1, 32'h0);
    tick();
    bus.lsu_req_i = 1'b0;
    #1;
    chk("t2_mem_addr", bus.mem_addr_o, 32'h20);
    chk("t2_mem_fields", {27'd0, bus.mem_we_o, bus.mem_be_o}, 32'h13);
    chk("t2_mem_wdata", bus.mem_wdata_o, 32'h12345678);
    mem_serve(0, 32'h0);
    #1;
    chk("t2_if_gnt_after", 32'(bus.if_gnt_o), 32'd1);
    push(1'b0, 32'hCAFEF00D);
    tick();
    bus.if_req_i = 1'b0;
    #1;
    chk("t2_if_addr", bus.mem_addr_o, 32'h44);
    chk("t2_if_fields", {27'd0, bus.mem_we_o, bus.mem_be_o}, 32'h0F);
    mem_serve(0, 32'hCAFEF00D);

    // mem_gnt_i withheld 5 cycles while both requesters wait
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h80;
    #1;
    chk("t3_if_gnt", 32'(bus.if_gnt_o), 32'd1);
    push(1'b0, 32'h11112222);
    tick();
    bus.lsu_req_i  = 1'b1;
    bus.lsu_we_i   = 1'b0;
    bus.lsu_be_i   = 4'hF;
    bus.lsu_addr_i = 32'h200;
    #1;
    chk("t3_mem_addr", bus.mem_addr_o, 32'h80);
    mem_serve(5, 32'h11112222);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h100;

    // Both requesting continuously: IF wins only on the 5th arbitration with the guard
    for (int n = 1; n <= 6; n++) begin
      exp_if = guard && (n == 5);
      #1;
      chk("t4_if_gnt", 32'(bus.if_gnt_o), 32'(exp_if));
      chk("t4_lsu_gnt", 32'(bus.lsu_gnt_o), 32'(!exp_if));
      push(!exp_if, 32'hA0 + 32'(n));
      tick();
      #1;
      chk("t4_mem_addr", bus.mem_addr_o, exp_if ? 32'h100 : 32'h200);
      mem_serve(0, 32'hA0 + 32'(n));
    end
    bus.lsu_req_i = 1'b0;

    // Reset during WAIT_RSP drops the transaction
    #1;
    chk("t5_if_gnt", 32'(bus.if_gnt_o), 32'd1);
    tick();
    bus.if_req_i  = 1'b0;
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i    = 1'b0;
    rstn_i           = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hBAD0BAD0;
    #1;
    chk("t5_rst_rvalid", {30'd0, bus.if_rvalid_o, bus.lsu_rvalid_o}, 32'd0);
    tick();
    rstn_i = 1'b1;
    #1;
    chk("t5_post_rvalid", {30'd0, bus.if_rvalid_o, bus.lsu_rvalid_o}, 32'd0);
    chk("t5_post_req", 32'(bus.mem_req_o), 32'd0);
    chk("t5_post_addr", bus.mem_addr_o, 32'd0);
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.lsu_req_i    = 1'b1;
    bus.lsu_we_i     = 1'b0;
    bus.lsu_addr_i   = 32'h40;
    #1;
    chk("t5_lsu_gnt", 32'(bus.lsu_gnt_o), 32'd1);
    push(1'b1, 32'h77778888);
    tick();
    bus.lsu_req_i = 1'b0;
    #1;
    chk("t5_mem_addr", bus.mem_addr_o, 32'h40);
    mem_serve(1, 32'h77778888);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
